// File: rtl/adder_arb_pkg.sv
// Shared constants and FSM encoding for the two-requester arbitrated adder.
package adder_arb_pkg;
    localparam int OP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        RESP = 2'd3
    } state_t;
endpackage

// File: rtl/adder_arb_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carry.
module cla32
    import adder_arb_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            ci,
    output logic [OP_W-1:0] s,
    output logic            co
);
    logic [OP_W-1:0] g;
    logic [OP_W-1:0] p;
    logic [OP_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c = '0;
        c[0] = ci;
        for (int k = 0; k < OP_W / 4; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
    end

    assign s  = p ^ c[OP_W-1:0];
    assign co = c[OP_W];
endmodule

// File: rtl/adder_arb.sv
// Two-requester arbiter sharing one cla32; FAIR selects round-robin or fixed priority.
module adder_arb
    import adder_arb_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic [OP_W-1:0] a0,
    input  logic [OP_W-1:0] b0,
    input  logic            ci0,
    output logic            ack0,
    input  logic            req1,
    input  logic [OP_W-1:0] a1,
    input  logic [OP_W-1:0] b1,
    input  logic            ci1,
    output logic            ack1,
    output logic [OP_W-1:0] s,
    output logic            co,
    output logic            owner,
    output logic            busy,
    output state_t          state_dbg
);
    // Four-phase handshake per requester: raise req with operands stable, ack
    // rises with s/co valid and holds while req stays high, drop req, ack falls
    // on the next edge. The non-owner waits until the FSM is back in IDLE.
    state_t          state, state_nxt;
    logic            last_owner;
    logic [OP_W-1:0] op_a, op_b;
    logic            op_ci;
    logic [OP_W-1:0] sum;
    logic            carry;
    logic            win, tie_win, req_own;
    logic            grant_en, load_en, add_en, done_en;

    assign tie_win   = FAIR ? ~last_owner : 1'b0;
    assign win       = req0 ? (req1 ? tie_win : 1'b0) : 1'b1;
    assign req_own   = owner ? req1 : req0;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        load_en   = 1'b0;
        add_en    = 1'b0;
        done_en   = 1'b0;
        case (state)
            IDLE: if (req0 | req1) begin
                grant_en  = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                load_en   = 1'b1;
                state_nxt = ADD;
            end
            ADD: begin
                add_en    = 1'b1;
                state_nxt = RESP;
            end
            RESP: if (!req_own) begin
                done_en   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    cla32 u_cla32 (
        .a  (op_a),
        .b  (op_b),
        .ci (op_ci),
        .s  (sum),
        .co (carry)
    );

    // last_owner resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_ci      <= 1'b0;
            s          <= '0;
            co         <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
        end else begin
            if (grant_en) owner <= win;
            if (load_en) begin
                op_a  <= owner ? a1 : a0;
                op_b  <= owner ? b1 : b0;
                op_ci <= owner ? ci1 : ci0;
            end
            if (add_en) begin
                s    <= sum;
                co   <= carry;
                ack0 <= ~owner;
                ack1 <= owner;
            end
            if (done_en) begin
                ack0       <= 1'b0;
                ack1       <= 1'b0;
                last_owner <= owner;
            end
        end
    end
endmodule
